// File: rtl/cfg_chain_receiver_pkg.sv
// Shared definitions for the configuration chain receiver and the controller-side checker.
package cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHK,
    ST_READY,
    ST_READBACK
  } cfg_state_e;

  localparam int          ADLER_MOD_DEFAULT = 65521;
  localparam logic [31:0] ADLER_INIT        = 32'h0000_0001;

  // Mask selecting the k most recently received bits of a partial byte.
  function automatic logic [7:0] low_mask(input logic [2:0] k);
    logic [8:0] m;
    m = (9'd1 << k) - 9'd1;
    return m[7:0];
  endfunction

endpackage

// File: rtl/cfg_chain_receiver_if.sv
// Serial load/readback bus between the configuration link and the fabric chain.
interface cfg_chain_if #(
  parameter int CHAIN_LEN = 256
);
  logic                 load_start;
  logic                 readback_start;
  logic                 prog_en;
  logic                 fpga_head;
  logic [31:0]          expected_len;
  logic                 fpga_tail;
  logic [CHAIN_LEN-1:0] cfg_bits;
  logic [31:0]          bit_count;
  logic [31:0]          adler_out;
  logic                 cfg_valid;
  logic                 busy;
  logic                 overflow;

  modport master (
    output load_start, readback_start, prog_en, fpga_head, expected_len,
    input  fpga_tail, cfg_bits, bit_count, adler_out, cfg_valid, busy, overflow
  );

  modport slave (
    input  load_start, readback_start, prog_en, fpga_head, expected_len,
    output fpga_tail, cfg_bits, bit_count, adler_out, cfg_valid, busy, overflow
  );
endinterface

// File: rtl/cfg_chain_receiver_adler32_step.sv
// One Adler-32 byte fold; 17-bit sums need at most one subtract since A, B < modulus.
module adler32_step #(
  parameter int MOD = 65521
) (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [7:0]  d_i,
  output logic [15:0] a_o,
  output logic [15:0] b_o
);
  localparam logic [16:0] MOD17 = 17'(MOD);

  logic [16:0] a_sum;
  logic [16:0] a_red;
  logic [16:0] b_sum;
  logic [16:0] b_red;

  always_comb begin
    a_sum = {1'b0, a_i} + {9'd0, d_i};
    a_red = (a_sum >= MOD17) ? (a_sum - MOD17) : a_sum;
    b_sum = {1'b0, b_i} + a_red;
    b_red = (b_sum >= MOD17) ? (b_sum - MOD17) : b_sum;
    a_o   = a_red[15:0];
    b_o   = b_red[15:0];
  end
endmodule

// File: rtl/cfg_chain_receiver.sv
// Fabric end of the configuration link: shifts serial bits into the chain, tracks
// length and Adler-32, and supports non-destructive circular readback.
module cfg_chain_receiver
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 256,
  parameter int ADLER_MOD = ADLER_MOD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  cfg_chain_if.slave  bus
);
  localparam int RB_W = $clog2(CHAIN_LEN) + 1;

  cfg_state_e           state_q;
  logic [CHAIN_LEN-1:0] chain_q;
  logic [31:0]          bit_count_q;
  logic [31:0]          len_q;
  logic [15:0]          a_q;
  logic [15:0]          b_q;
  logic [31:0]          adler_q;
  logic                 cfg_valid_q;
  logic                 overflow_q;
  logic [7:0]           byte_acc_q;
  logic [RB_W-1:0]      rb_cnt_q;

  logic [7:0]  fold_d;
  logic [15:0] a_d;
  logic [15:0] b_d;
  logic [32:0] cnt_inc;

  // One fold unit serves both full bytes in LOAD and the trailing partial byte in CHK.
  always_comb begin
    fold_d  = {byte_acc_q[6:0], bus.fpga_head};
    if (state_q == ST_CHK) begin
      fold_d = byte_acc_q & low_mask(bit_count_q[2:0]);
    end
    cnt_inc = {1'b0, bit_count_q} + 33'd1;
  end

  adler32_step #(.MOD(ADLER_MOD)) u_step (
    .a_i (a_q),
    .b_i (b_q),
    .d_i (fold_d),
    .a_o (a_d),
    .b_o (b_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      chain_q     <= '0;
      bit_count_q <= '0;
      len_q       <= '0;
      a_q         <= ADLER_INIT[15:0];
      b_q         <= ADLER_INIT[31:16];
      adler_q     <= '0;
      cfg_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      byte_acc_q  <= '0;
      rb_cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_READY: begin
          if (bus.load_start) begin
            state_q     <= ST_LOAD;
            len_q       <= bus.expected_len;
            bit_count_q <= '0;
            byte_acc_q  <= '0;
            overflow_q  <= 1'b0;
            cfg_valid_q <= 1'b0;
            a_q         <= ADLER_INIT[15:0];
            b_q         <= ADLER_INIT[31:16];
          end else if (state_q == ST_READY && bus.readback_start) begin
            state_q  <= ST_READBACK;
            rb_cnt_q <= '0;
          end
        end

        ST_LOAD: begin
          if (len_q == 32'd0) begin
            state_q <= ST_CHK;
          end else if (bus.prog_en) begin
            chain_q     <= {chain_q[CHAIN_LEN-2:0], bus.fpga_head};
            bit_count_q <= cnt_inc[31:0];
            byte_acc_q  <= {byte_acc_q[6:0], bus.fpga_head};
            if (bit_count_q[2:0] == 3'd7) begin
              a_q <= a_d;
              b_q <= b_d;
            end
            if (cnt_inc > 33'(CHAIN_LEN)) begin
              overflow_q <= 1'b1;
            end
            if (cnt_inc == {1'b0, len_q}) begin
              state_q <= ST_CHK;
            end
          end
        end

        ST_CHK: begin
          if (bit_count_q[2:0] != 3'd0) begin
            a_q     <= a_d;
            b_q     <= b_d;
            adler_q <= {b_d, a_d};
          end else begin
            adler_q <= {b_q, a_q};
          end
          cfg_valid_q <= 1'b1;
          state_q     <= ST_READY;
        end

        ST_READBACK: begin
          if (bus.prog_en) begin
            chain_q  <= {chain_q[CHAIN_LEN-2:0], chain_q[CHAIN_LEN-1]};
            rb_cnt_q <= rb_cnt_q + RB_W'(1);
            if (rb_cnt_q == RB_W'(CHAIN_LEN - 1)) begin
              state_q <= ST_READY;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.fpga_tail = chain_q[CHAIN_LEN-1];
  assign bus.cfg_bits  = chain_q;
  assign bus.bit_count = bit_count_q;
  assign bus.adler_out = adler_q;
  assign bus.cfg_valid = cfg_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = (state_q == ST_LOAD) || (state_q == ST_CHK) || (state_q == ST_READBACK);

endmodule

// File: tb/tb_cfg_chain_receiver.sv
// Directed bench for cfg_chain_receiver with a bit-list/Adler reference model.
module tb_cfg_chain_receiver;
  localparam int CL = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cfg_chain_if #(.CHAIN_LEN(CL)) bus ();

  cfg_chain_receiver #(.CHAIN_LEN(CL), .ADLER_MOD(65521)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: phase 0 idle, 1 load, 2 checksum, 3 ready, 4 readback
  int          phase   = 0;
  logic [CL-1:0] m_chain = '0;
  int          m_cnt   = 0;
  int          m_len   = 0;
  int          m_rb    = 0;
  bit          m_valid = 0;
  bit          m_ovf   = 0;
  logic [31:0] m_adler = '0;
  bit          m_bits[$];
  bit          started = 0;

  function automatic logic [31:0] adler_of(input bit bits[$]);
    int a = 1;
    int b = 0;
    int i = 0;
    while (i < bits.size()) begin
      int d = 0;
      for (int j = 0; j < 8 && i < bits.size(); j++) begin
        d = d * 2 + int'(bits[i]);
        i++;
      end
      a = (a + d) % 65521;
      b = (b + a) % 65521;
    end
    return {b[15:0], a[15:0]};
  endfunction

  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      phase = 0; m_chain = '0; m_cnt = 0; m_valid = 0; m_ovf = 0;
      m_adler = '0; m_bits.delete();
    end else begin
      case (phase)
        0, 3: begin
          if (bus.load_start) begin
            phase = 1; m_len = int'(bus.expected_len); m_cnt = 0;
            m_ovf = 0; m_valid = 0; m_bits.delete();
          end else if (phase == 3 && bus.readback_start) begin
            phase = 4; m_rb = 0;
          end
        end
        1: begin
          if (m_len == 0) phase = 2;
          else if (bus.prog_en) begin
            m_chain = {m_chain[CL-2:0], bus.fpga_head};
            m_bits.push_back(bus.fpga_head);
            m_cnt++;
            if (m_cnt > CL) m_ovf = 1;
            if (m_cnt == m_len) phase = 2;
          end
        end
        2: begin
          m_adler = adler_of(m_bits); m_valid = 1; phase = 3;
        end
        4: begin
          if (bus.prog_en) begin
            m_chain = {m_chain[CL-2:0], m_chain[CL-1]};
            m_rb++;
            if (m_rb == CL) phase = 3;
          end
        end
        default: phase = 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("cmp_cfg_bits", 32'(bus.cfg_bits), 32'(m_chain));
      chk("cmp_bit_count", bus.bit_count, 32'(m_cnt));
      chk("cmp_cfg_valid", 32'(bus.cfg_valid), 32'(m_valid));
      chk("cmp_busy", 32'(bus.busy), 32'(phase == 1 || phase == 2 || phase == 4));
      chk("cmp_overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("cmp_fpga_tail", 32'(bus.fpga_tail), 32'(m_chain[CL-1]));
      if (m_valid) chk("cmp_adler", bus.adler_out, m_adler);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int len);
    bus.load_start   = 1'b1;
    bus.expected_len = 32'(len);
    tick();
    bus.load_start   = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] val, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      bus.prog_en   = 1'b1;
      bus.fpga_head = val[i];
      tick();
      bus.prog_en   = 1'b0;
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.cfg_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.cfg_valid) begin
      errors++;
      $display("FAIL %s: cfg_valid still %b after %0d cycles, required 1", name, bus.cfg_valid, n);
    end
  endtask

  logic [15:0] rb_pat;

  initial begin
    reset = 1'b1;
    bus.load_start = 0; bus.readback_start = 0; bus.prog_en = 0;
    bus.fpga_head = 0; bus.expected_len = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_cfg_valid", 32'(bus.cfg_valid), 0);
    chk("rst_adler", bus.adler_out, 0);
    chk("rst_busy", 32'(bus.busy), 0);

    // 1: single byte 0x61
    start_load(8);
    send_bits(32'h61, 8, 0);
    chk("t1_valid_in_chk", 32'(bus.cfg_valid), 0);
    tick();
    chk("t1_valid_latency", 32'(bus.cfg_valid), 1);
    chk("t1_adler", bus.adler_out, 32'h0062_0062);
    chk("t1_count", bus.bit_count, 8);
    chk("t1_bits", 32'(bus.cfg_bits[7:0]), 32'h61);

    // 2: zero-length load
    start_load(0);
    wait_valid("t2_wait");
    chk("t2_adler", bus.adler_out, 32'h0000_0001);
    chk("t2_count", bus.bit_count, 0);

    // 3: partial byte; readback_start during LOAD must be ignored
    start_load(4);
    bus.readback_start = 1'b1;
    send_bits(32'hB, 1, 0);
    bus.readback_start = 1'b0;
    send_bits(32'h3, 3, 1);
    wait_valid("t3_wait");
    chk("t3_adler", bus.adler_out, 32'h000C_000C);
    chk("t3_busy", 32'(bus.busy), 0);

    // 4: overflow past the chain length
    start_load(20);
    send_bits(32'hF_A5C3, 20, 0);
    wait_valid("t4_wait");
    chk("t4_overflow", 32'(bus.overflow), 1);
    chk("t4_bits", 32'(bus.cfg_bits), 32'hA5C3);
    chk("t4_tail", 32'(bus.fpga_tail), 1);

    // 5: gapped load then full circular readback
    start_load(16);
    send_bits(32'hA5C3, 16, 1);
    wait_valid("t5_wait");
    chk("t5_overflow", 32'(bus.overflow), 0);
    bus.readback_start = 1'b1;
    tick();
    bus.readback_start = 1'b0;
    rb_pat = 16'b1010010111000011;
    for (int i = 15; i >= 0; i--) begin
      repeat ($urandom_range(0, 2)) tick();
      chk("t5_tail_seq", 32'(bus.fpga_tail), 32'(rb_pat[i]));
      bus.load_start = (i == 8);
      bus.prog_en    = 1'b1;
      tick();
      bus.prog_en    = 1'b0;
      bus.load_start = 1'b0;
    end
    tick();
    chk("t5_restored", 32'(bus.cfg_bits), 32'hA5C3);
    chk("t5_valid_kept", 32'(bus.cfg_valid), 1);
    chk("t5_busy_done", 32'(bus.busy), 0);
    chk("t5_count_kept", bus.bit_count, 16);

    // 6: reset mid-load, then a clean reload
    start_load(8);
    send_bits(32'h0C, 5, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_count", bus.bit_count, 0);
    chk("t6_valid", 32'(bus.cfg_valid), 0);
    chk("t6_chain", 32'(bus.cfg_bits), 0);
    chk("t6_busy", 32'(bus.busy), 0);
    start_load(8);
    send_bits(32'h61, 8, 1);
    wait_valid("t6_wait");
    chk("t6_adler", bus.adler_out, 32'h0062_0062);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
